// File: rtl/reg_readout_serializer.sv
// Purpose: captures an N-bit register word on load_req/ready and shifts it out MSB-first as ser_data/ser_clk, then pulses ser_latch.
// Latency: ready falls the cycle after capture; ser_latch at N*DIV+1, ready back at N*DIV+2 (one extra DIV period when SER_PARITY_EN is defined).
// Backpressure: load_req is honoured only while ready=1; requests during a frame are dropped, not queued.
module reg_readout_serializer #(
    parameter int N   = 16,
    parameter int DIV = 4
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic [N-1:0] REG_VALUE,
    input  logic         load_req,
    output logic         ready,
    output logic         busy,
    output logic         ser_data,
    output logic         ser_clk,
    output logic         ser_latch
);

`ifdef SER_PARITY_EN
    localparam int NBITS = N + 1;
`else
    localparam int NBITS = N;
`endif

    localparam int DW = $clog2(DIV);
    localparam int CW = $clog2(NBITS + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] HALF_M1  = DW'(DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t          state;
    logic [N-1:0]    shreg;
    logic [CW-1:0]   bitcnt;
    logic [DW-1:0]   divcnt;
    logic            next_bit;

`ifdef SER_PARITY_EN
    logic            par;

    // Bit presented after the current one: parity follows the last data bit.
    always_comb begin
        next_bit = shreg[N-2];
        if (bitcnt == CW'(N - 1)) begin
            next_bit = par;
        end
    end

    // Even parity of the captured word, frozen for the whole frame.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            par <= 1'b0;
        end else if (state == IDLE && load_req && ready) begin
            par <= ^REG_VALUE;
        end
    end
`else
    // Bit presented after the current one is the next shift register MSB.
    always_comb begin
        next_bit = shreg[N-2];
    end
`endif

    // Frame FSM: all link outputs are registered and computed from the next-cycle state.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            shreg     <= '0;
            bitcnt    <= '0;
            divcnt    <= '0;
            ready     <= 1'b1;
            busy      <= 1'b0;
            ser_data  <= 1'b0;
            ser_clk   <= 1'b0;
            ser_latch <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_req && ready) begin
                        state    <= SHIFT;
                        shreg    <= REG_VALUE;
                        bitcnt   <= '0;
                        divcnt   <= '0;
                        ready    <= 1'b0;
                        busy     <= 1'b1;
                        ser_data <= REG_VALUE[N-1];
                        ser_clk  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (divcnt == DIV_LAST) begin
                        divcnt  <= '0;
                        ser_clk <= 1'b0;
                        shreg   <= {shreg[N-2:0], 1'b0};
                        bitcnt  <= bitcnt + 1'b1;
                        if (bitcnt == BIT_LAST) begin
                            state     <= LATCH;
                            ser_data  <= 1'b0;
                            ser_latch <= 1'b1;
                        end else begin
                            ser_data <= next_bit;
                        end
                    end else begin
                        divcnt  <= divcnt + 1'b1;
                        // High for the second half of the bit period.
                        ser_clk <= (divcnt >= HALF_M1);
                    end
                end
                LATCH: begin
                    state     <= IDLE;
                    ser_latch <= 1'b0;
                    ready     <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    ser_latch <= 1'b0;
                    ser_data  <= 1'b0;
                    ser_clk   <= 1'b0;
                    ready     <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_readout_serializer.sv
module tb_reg_readout_serializer;

`ifdef SER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FL_A = 16 * 4 + 2 + PB * 4;
    localparam int FL_B = 16 * 2 + 2 + PB * 2;
    localparam int NB   = 16 + PB;

    logic        clk = 1'b0;
    logic        Reset;
    logic [15:0] reg_a, reg_b;
    logic        load_a, load_b;
    logic        a_ready, a_busy, a_data, a_sclk, a_latch;
    logic        b_ready, b_busy, b_data, b_sclk, b_latch;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    reg_readout_serializer #(.N(16), .DIV(4)) dut_a (
        .clk(clk), .Reset(Reset), .REG_VALUE(reg_a), .load_req(load_a),
        .ready(a_ready), .busy(a_busy), .ser_data(a_data), .ser_clk(a_sclk), .ser_latch(a_latch)
    );

    reg_readout_serializer #(.N(16), .DIV(2)) dut_b (
        .clk(clk), .Reset(Reset), .REG_VALUE(reg_b), .load_req(load_b),
        .ready(b_ready), .busy(b_busy), .ser_data(b_data), .ser_clk(b_sclk), .ser_latch(b_latch)
    );

    // Word as it appears on the link: data bits, then parity when enabled.
    function automatic logic [63:0] link_bits(input logic [15:0] w);
        logic [63:0] r;
        r = {48'd0, w};
        if (PB == 1) r = {r[62:0], ^w};
        return r;
    endfunction

    // Starts a frame (cycle 0 = cycle in which load_req is presented) and monitors ncyc cycles.
    task automatic run_frame(input bit sel, input logic [15:0] v0, input logic [15:0] v1,
                             input bit hold, input int p1, input int p2, input int ncyc,
                             output logic [63:0] bits, output int nbits, output int first_rise,
                             output int latch_first, output int nlatch, output int ready_first,
                             output int refall, output int busy_bad);
        logic pclk, prdy, c_clk, c_dat, c_lat, c_rdy, c_busy, lr;
        int fl;
        fl = sel ? FL_B : FL_A;
        bits = '0; nbits = 0; first_rise = -1; latch_first = -1; nlatch = 0;
        ready_first = -1; refall = -1; busy_bad = 0;
        @(negedge clk);
        if (sel) begin reg_b = v0; load_b = 1'b1; end
        else     begin reg_a = v0; load_a = 1'b1; end
        pclk = 1'b0; prdy = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            c_clk  = sel ? b_sclk  : a_sclk;
            c_dat  = sel ? b_data  : a_data;
            c_lat  = sel ? b_latch : a_latch;
            c_rdy  = sel ? b_ready : a_ready;
            c_busy = sel ? b_busy  : a_busy;
            if (c_clk && !pclk) begin
                bits = {bits[62:0], c_dat};
                nbits++;
                if (first_rise < 0) first_rise = c;
            end
            if (c_lat) begin
                nlatch++;
                if (latch_first < 0) latch_first = c;
            end
            if (c_rdy && ready_first < 0) ready_first = c;
            if (!c_rdy && prdy && c > 1 && refall < 0) refall = c;
            if (c_busy === c_rdy) busy_bad++;
            pclk = c_clk; prdy = c_rdy;
            lr = hold ? (c <= fl) : (c == p1 || c == p2);
            if (sel) begin reg_b = v1; load_b = lr; end
            else     begin reg_a = v1; load_a = lr; end
        end
        load_a = 1'b0; load_b = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b0; load_a = 1'b0; load_b = 1'b0; reg_a = '0; reg_b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_ready, a_busy, a_data, a_sclk, a_latch} !== 5'b10000)
            $display("FAIL reset_a outputs got %b want 10000", {a_ready, a_busy, a_data, a_sclk, a_latch});
        else passed++;
        checks++;
        if ({b_ready, b_busy, b_data, b_sclk, b_latch} !== 5'b10000)
            $display("FAIL reset_b outputs got %b want 10000", {b_ready, b_busy, b_data, b_sclk, b_latch});
        else passed++;
        Reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_frame;
        logic [63:0] bits; int nb, fr, lf, nl, rf, rfall, bb;
        run_frame(1'b0, 16'hA5C3, 16'hA5C3, 1'b0, -1, -1, FL_A + 10, bits, nb, fr, lf, nl, rf, rfall, bb);
        checks++; if (bits !== link_bits(16'hA5C3)) $display("FAIL a5c3_bits got %h want %h", bits, link_bits(16'hA5C3)); else passed++;
        checks++; if (nb !== NB) $display("FAIL a5c3_nbits got %0d want %0d", nb, NB); else passed++;
        checks++; if (fr !== 3) $display("FAIL a5c3_first_rise got %0d want 3", fr); else passed++;
        checks++; if (lf !== FL_A - 1) $display("FAIL a5c3_latch_cycle got %0d want %0d", lf, FL_A - 1); else passed++;
        checks++; if (nl !== 1) $display("FAIL a5c3_latch_count got %0d want 1", nl); else passed++;
        checks++; if (rf !== FL_A) $display("FAIL a5c3_ready_cycle got %0d want %0d", rf, FL_A); else passed++;
        checks++; if (bb !== 0) $display("FAIL a5c3_busy_not_ready got %0d bad cycles want 0", bb); else passed++;
    endtask

    task automatic test_ignore_requests;
        logic [63:0] bits; int nb, fr, lf, nl, rf, rfall, bb;
        run_frame(1'b0, 16'h1234, 16'h1234, 1'b0, 10, 40, FL_A + 80, bits, nb, fr, lf, nl, rf, rfall, bb);
        checks++; if (bits !== link_bits(16'h1234)) $display("FAIL ignore_bits got %h want %h", bits, link_bits(16'h1234)); else passed++;
        checks++; if (nb !== NB) $display("FAIL ignore_nbits got %0d want %0d", nb, NB); else passed++;
        checks++; if (nl !== 1) $display("FAIL ignore_latch_count got %0d want 1", nl); else passed++;
        checks++; if (rfall !== -1) $display("FAIL ignore_second_frame started at %0d want none", rfall); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [63:0] bits, exp; int nb, fr, lf, nl, rf, rfall, bb;
        run_frame(1'b0, 16'hFFFF, 16'h0000, 1'b1, -1, -1, 2 * FL_A + 4, bits, nb, fr, lf, nl, rf, rfall, bb);
        exp = (link_bits(16'hFFFF) << NB) | link_bits(16'h0000);
        checks++; if (bits !== exp) $display("FAIL b2b_bits got %h want %h", bits, exp); else passed++;
        checks++; if (nb !== 2 * NB) $display("FAIL b2b_nbits got %0d want %0d", nb, 2 * NB); else passed++;
        checks++; if (nl !== 2) $display("FAIL b2b_latch_count got %0d want 2", nl); else passed++;
        checks++; if (rf !== FL_A) $display("FAIL b2b_ready_cycle got %0d want %0d", rf, FL_A); else passed++;
        checks++; if (rfall !== FL_A + 1) $display("FAIL b2b_second_start got %0d want %0d", rfall, FL_A + 1); else passed++;
    endtask

    task automatic test_reset_midframe;
        logic [63:0] bits; int nb, fr, lf, nl, rf, rfall, bb, bad;
        @(negedge clk);
        reg_a = 16'hBEEF; load_a = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            load_a = 1'b0;
        end
        checks++; if ({a_ready, a_sclk} !== 2'b01) $display("FAIL midframe_pre_reset ready/sclk got %b want 01", {a_ready, a_sclk}); else passed++;
        Reset = 1'b0;
        #1;
        checks++;
        if ({a_ready, a_busy, a_data, a_sclk, a_latch} !== 5'b10000)
            $display("FAIL midframe_async_reset got %b want 10000", {a_ready, a_busy, a_data, a_sclk, a_latch});
        else passed++;
        repeat (3) @(negedge clk);
        Reset = 1'b1;
        bad = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (a_latch || a_sclk || !a_ready) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL midframe_quiet_after_release got %0d active cycles want 0", bad); else passed++;
        run_frame(1'b0, 16'h0001, 16'h0001, 1'b0, -1, -1, FL_A + 5, bits, nb, fr, lf, nl, rf, rfall, bb);
        checks++; if (bits !== link_bits(16'h0001)) $display("FAIL post_reset_bits got %h want %h", bits, link_bits(16'h0001)); else passed++;
        checks++; if (nb !== NB) $display("FAIL post_reset_nbits got %0d want %0d", nb, NB); else passed++;
        checks++; if (lf !== FL_A - 1) $display("FAIL post_reset_latch got %0d want %0d", lf, FL_A - 1); else passed++;
    endtask

    task automatic test_div2;
        logic [63:0] bits; int nb, fr, lf, nl, rf, rfall, bb;
        run_frame(1'b1, 16'h8001, 16'h8001, 1'b0, -1, -1, FL_B + 6, bits, nb, fr, lf, nl, rf, rfall, bb);
        checks++; if (bits !== link_bits(16'h8001)) $display("FAIL div2_bits got %h want %h", bits, link_bits(16'h8001)); else passed++;
        checks++; if (nb !== NB) $display("FAIL div2_nbits got %0d want %0d", nb, NB); else passed++;
        checks++; if (fr !== 2) $display("FAIL div2_first_rise got %0d want 2", fr); else passed++;
        checks++; if (lf !== FL_B - 1) $display("FAIL div2_latch_cycle got %0d want %0d", lf, FL_B - 1); else passed++;
        checks++; if (rf !== FL_B) $display("FAIL div2_ready_cycle got %0d want %0d", rf, FL_B); else passed++;
        checks++; if (bb !== 0) $display("FAIL div2_busy_not_ready got %0d bad cycles want 0", bb); else passed++;
    endtask

`ifdef SER_PARITY_EN
    task automatic test_parity;
        logic [63:0] bits; int nb, fr, lf, nl, rf, rfall, bb;
        run_frame(1'b0, 16'h0001, 16'h0001, 1'b0, -1, -1, FL_A + 5, bits, nb, fr, lf, nl, rf, rfall, bb);
        checks++; if (nb !== 17) $display("FAIL parity_nbits got %0d want 17", nb); else passed++;
        checks++; if (bits[0] !== 1'b1) $display("FAIL parity_0001 got %b want 1", bits[0]); else passed++;
        checks++; if (lf !== 69) $display("FAIL parity_latch got %0d want 69", lf); else passed++;
        checks++; if (rf !== 70) $display("FAIL parity_ready got %0d want 70", rf); else passed++;
        run_frame(1'b0, 16'h0003, 16'h0003, 1'b0, -1, -1, FL_A + 5, bits, nb, fr, lf, nl, rf, rfall, bb);
        checks++; if (bits[0] !== 1'b0) $display("FAIL parity_0003 got %b want 0", bits[0]); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_ignore_requests();
        test_back_to_back();
        test_reset_midframe();
        test_div2();
`ifdef SER_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/reg_readout_serializer.md
# reg_readout_serializer

Parallel-to-serial readout port for the CPU's 16-bit register words. It is the reader side of the load-enabled register: it captures a register's output word on a request/ready handshake and shifts it out MSB-first on a clocked serial link (data, shift clock, latch strobe). The link feeds external display/debug shift registers, such as the PONG LED driver chain. One frame is sent per accepted capture.

## Interface
- `N`, default 16: word width; legal range ≥2.
- `DIV`, default 4: clk cycles per serial bit; legal values even, ≥2.

- `clk`  in  1: system clock; all state updates on the rising edge.
- `Reset`  in  1: asynchronous, active-low reset; state clears while low.
- `REG_VALUE`  in  N: parallel word, typically a register's output bus.
- `load_req`  in  1: capture request; sampled on the rising edge.
- `ready`  out  1: high when idle and able to accept a capture.
- `busy`  out  1: high while a frame is in progress; equals ~ready.
- `ser_data`  out  1: serial data, MSB first.
- `ser_clk`  out  1: serial shift clock; the receiver samples `ser_data` on its rising edge.
- `ser_latch`  out  1: one-cycle strobe after the last bit of a frame.

## Operation
- All outputs are registered.
- Reset values: `ready`=1, `busy`=0, `ser_data`=0, `ser_clk`=0, `ser_latch`=0. Internal state on reset: shift register 0, bit counter 0, divider counter 0, state IDLE.
- **IDLE**:
  - A capture occurs on a rising edge with `load_req`=1 and `ready`=1.
  - On capture: `REG_VALUE` loads into the shift register, counters clear, and the block moves to SHIFT.
  - `load_req` while not in IDLE is ignored; it is not queued.
- **SHIFT**:
  - `ser_data` = shift register MSB.
  - The divider counter runs 0..DIV-1.
  - `ser_clk` = 1 when divider ≥ DIV/2, otherwise 0.
  - At divider = DIV-1, the shift register shifts left by one (zero fill) and the bit counter increments.
  - After bit N-1 completes, the block moves to LATCH.
- **LATCH**:
  - `ser_latch`=1 for exactly one cycle; `ser_data`=0 and `ser_clk`=0.
  - Then the block returns to IDLE.
- Reset asserted mid-frame:
  - The frame is abandoned immediately and all outputs take their reset values.
  - No `ser_latch` is issued for the abandoned frame.
  - After reset releases, the next frame starts only on a new capture.
- `REG_VALUE` changes after capture do not affect the frame in flight.

## Timing
- The capture edge is cycle 0.
- `ready` falls and `busy` rises in cycle 1, which is also the first SHIFT cycle.
- Bit k (k=0 is the MSB) occupies cycles 1+k·DIV .. (k+1)·DIV.
  - `ser_clk` rises at cycle 1+k·DIV+DIV/2.
  - `ser_data` is stable for the whole bit period.
- `ser_latch` is high in cycle N·DIV+1.
- `ready` returns to 1 in cycle N·DIV+2.
- Frame length is N·DIV+2 cycles from capture edge to ready.
- Back-to-back operation: with `load_req` held high, the next capture occurs on the first edge where `ready`=1. The maximum rate is one frame per N·DIV+2 cycles.

## Configuration
- `SER_PARITY_EN` defined:
  - One extra bit period follows data bit N-1, before LATCH.
  - That period carries the even-parity bit, which is the XOR of the captured word, with the same `ser_clk` shape as a data bit.
  - `ser_latch` is at cycle (N+1)·DIV+1; `ready` returns at (N+1)·DIV+2.
- Undefined: no parity period; timing is exactly as given above.

## Test plan
- N=16, DIV=4, capture 0xA5C3:
  - Bits sampled at the 16 `ser_clk` rising edges = 1010_0101_1100_0011.
  - First `ser_clk` rise at cycle 3.
  - `ser_latch` high only in cycle 65; `ready`=1 at cycle 66.
- Pulse `load_req` in cycles 10 and 40 of a frame for 0x1234: both requests are ignored. Exactly 16 bits and one latch are sent, and no second frame follows.
- Hold `load_req`=1 with `REG_VALUE` switching 0xFFFF then 0x0000:
  - Two consecutive frames, with captures at cycles 0 and 66.
  - Sampled words 0xFFFF then 0x0000.
- Drive `Reset` low at cycle 20 of a 0xBEEF frame:
  - All outputs return to reset values asynchronously; no latch is issued.
  - After release, a new capture of 0x0001 sends a clean frame.
- DIV=2, capture 0x8001:
  - `ser_clk` toggles every cycle; bits are 1, fourteen 0s, then 1.
  - Latch at cycle 33, `ready` at cycle 34.
- With `SER_PARITY_EN`, N=16, DIV=4, capture 0x0001:
  - 17 sampled bits; the 17th (parity) bit = 1.
  - Latch at cycle 69; `ready` at cycle 70.
  - Repeating with 0x0003 gives parity bit 0.
